// File: rtl/booth_mult_sched.sv
// Two-requester round-robin scheduler feeding a sequential radix-2 Booth multiplier.
// Define BOOTH_MULT_SCHED_STATS_EN to add the saturating ops_done result counter.
module booth_mult_sched #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [DATA_WIDTH-1:0]     req0_m,
  input  logic [DATA_WIDTH-1:0]     req0_q,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [DATA_WIDTH-1:0]     req1_m,
  input  logic [DATA_WIDTH-1:0]     req1_q,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [2*DATA_WIDTH-1:0]   res_product,
`ifdef BOOTH_MULT_SCHED_STATS_EN
  output logic [15:0]               ops_done,
`endif
  output logic                      res_id
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned CW = (DW > 2) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic [DW-1:0]   m_q, m_d;
  logic [DW:0]     a_q, a_d;
  logic [DW-1:0]   qr_q, qr_d;
  logic            qm1_q, qm1_d;
  logic [CW-1:0]   count_q, count_d;
  logic            id_q, id_d;
  logic            res_valid_q, res_valid_d;
  logic [PW-1:0]   res_product_q, res_product_d;
  logic            res_id_q, res_id_d;

  logic            grant0_c, grant1_c;
  logic [DW:0]     a_sum_c, a_sh_c;
  logic [DW-1:0]   q_sh_c;

  // Single valid wins outright; a tie goes to the round-robin pointer.
  assign grant0_c = req0_valid & (~req1_valid | ~rr_ptr_q);
  assign grant1_c = req1_valid & (~req0_valid |  rr_ptr_q);

  // One Booth step: add/subtract sign-extended M, then arithmetic shift of {A,Q,q-1}.
  always_comb begin
    a_sum_c = a_q;
    unique case ({qr_q[0], qm1_q})
      2'b10:   a_sum_c = a_q - {m_q[DW-1], m_q};
      2'b01:   a_sum_c = a_q + {m_q[DW-1], m_q};
      default: a_sum_c = a_q;
    endcase
    a_sh_c = {a_sum_c[DW], a_sum_c[DW:1]};
    q_sh_c = {a_sum_c[0], qr_q[DW-1:1]};
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    m_d           = m_q;
    a_d           = a_q;
    qr_d          = qr_q;
    qm1_d         = qm1_q;
    count_d       = count_q;
    id_d          = id_q;
    res_valid_d   = res_valid_q;
    res_product_d = res_product_q;
    res_id_d      = res_id_q;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req0_ready = grant0_c;
        req1_ready = grant1_c;
        if (grant0_c | grant1_c) begin
          m_d      = grant1_c ? req1_m : req0_m;
          qr_d     = grant1_c ? req1_q : req0_q;
          a_d      = '0;
          qm1_d    = 1'b0;
          count_d  = '0;
          id_d     = grant1_c;
          rr_ptr_d = ~grant1_c;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        a_d     = a_sh_c;
        qr_d    = q_sh_c;
        qm1_d   = qr_q[0];
        count_d = count_q + CW'(1);
        if (count_q == LAST_ITER) begin
          res_product_d = {a_sh_c[DW-1:0], q_sh_c};
          res_id_d      = id_q;
          res_valid_d   = 1'b1;
          state_d       = DONE;
        end
      end
      DONE: begin
        if (res_valid_q & res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= 1'b0;
      m_q           <= '0;
      a_q           <= '0;
      qr_q          <= '0;
      qm1_q         <= 1'b0;
      count_q       <= '0;
      id_q          <= 1'b0;
      res_valid_q   <= 1'b0;
      res_product_q <= '0;
      res_id_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      m_q           <= m_d;
      a_q           <= a_d;
      qr_q          <= qr_d;
      qm1_q         <= qm1_d;
      count_q       <= count_d;
      id_q          <= id_d;
      res_valid_q   <= res_valid_d;
      res_product_q <= res_product_d;
      res_id_q      <= res_id_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_product = res_product_q;
  assign res_id      = res_id_q;

`ifdef BOOTH_MULT_SCHED_STATS_EN
  logic [15:0] ops_done_q, ops_done_d;

  // Counts consumed results, sticking at all-ones.
  always_comb begin
    ops_done_d = ops_done_q;
    if (res_valid_q & res_ready & (ops_done_q != 16'hFFFF)) begin
      ops_done_d = ops_done_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ops_done_q <= '0;
    else        ops_done_q <= ops_done_d;
  end

  assign ops_done = ops_done_q;
`endif

endmodule

// File: tb/tb_booth_mult_sched.sv
// Directed self-checking bench for booth_mult_sched at DATA_WIDTH=8.
module tb_booth_mult_sched;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_m, req0_q, req1_m, req1_q;
  logic          res_valid, res_ready, res_id;
  logic [2*DW-1:0] res_product;
`ifdef BOOTH_MULT_SCHED_STATS_EN
  logic [15:0]   ops_done;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  booth_mult_sched #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_m      (req0_m),
    .req0_q      (req0_q),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_m      (req1_m),
    .req1_q      (req1_q),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_product (res_product),
`ifdef BOOTH_MULT_SCHED_STATS_EN
    .ops_done    (ops_done),
`endif
    .res_id      (res_id)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents one pair on a single requester and lets it be accepted.
  task automatic launch(input logic id, input logic [DW-1:0] m, input logic [DW-1:0] q);
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_m = m; req1_q = q; end
    else    begin req0_valid = 1'b1; req0_m = m; req0_q = q; end
    #1;
    check("ready_idle", 32'({req1_ready, req0_ready}), id ? 32'h2 : 32'h1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_m = ~m; req0_q = ~q; req1_m = ~m; req1_q = ~q;
    check("ready_pulse", 32'({req1_ready, req0_ready}), 32'h0);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!res_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("res_valid_clr", 32'(res_valid), 32'h0);
  endtask

  task automatic single_op(input logic id, input logic [DW-1:0] m, input logic [DW-1:0] q,
                           input logic [2*DW-1:0] exp);
    int lat;
    launch(id, m, q);
    wait_result(lat);
    check("latency", 32'(lat), 32'd8);
    check("product", 32'(res_product), 32'(exp));
    check("res_id", 32'(res_id), 32'(id));
    consume();
  endtask

  initial begin
    int lat;
    int t;
    logic [2*DW-1:0] held;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    req0_m = '0; req0_q = '0; req1_m = '0; req1_q = '0;
    #12;
    check("rst_valid", 32'(res_valid), 32'h0);
    check("rst_product", 32'(res_product), 32'h0);
    check("rst_id", 32'(res_id), 32'h0);
    check("rst_ready", 32'({req1_ready, req0_ready}), 32'h0);
`ifdef BOOTH_MULT_SCHED_STATS_EN
    check("rst_ops", 32'(ops_done), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed products, including the most-negative corner cases.
    single_op(1'b0, 8'd3,    8'hFC, 16'hFFF4);
    single_op(1'b0, 8'h80,   8'h80, 16'h4000);
    single_op(1'b1, 8'h80,   8'h7F, 16'hC080);
    single_op(1'b0, 8'h00,   8'hFF, 16'h0000);
    single_op(1'b1, 8'h7F,   8'h7F, 16'h3F01);
    single_op(1'b0, 8'hFF,   8'hFF, 16'h0001);
`ifdef BOOTH_MULT_SCHED_STATS_EN
    check("ops_done_6", 32'(ops_done), 32'd6);
`endif

    // Hold result in DONE with a competing request pending.
    launch(1'b0, 8'd10, 8'd10);
    req1_valid = 1'b1; req1_m = 8'd2; req1_q = 8'd3;
    wait_result(lat);
    check("hold_latency", 32'(lat), 32'd8);
    held = res_product;
    check("hold_product", 32'(held), 32'h0064);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_stable", 32'({res_valid, res_id, res_product}), 32'({1'b1, 1'b0, 16'h0064}));
      check("hold_noready", 32'({req1_ready, req0_ready}), 32'h0);
    end
`ifdef BOOTH_MULT_SCHED_STATS_EN
    check("ops_held", 32'(ops_done), 32'd6);
`endif
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("hold_release", 32'(res_valid), 32'h0);
    check("next_ready", 32'({req1_ready, req0_ready}), 32'h2);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    wait_result(lat);
    check("r1_latency", 32'(lat), 32'd8);
    check("r1_product", 32'(res_product), 32'h0006);
    check("r1_id", 32'(res_id), 32'h1);
    consume();
`ifdef BOOTH_MULT_SCHED_STATS_EN
    check("ops_done_8", 32'(ops_done), 32'd8);
`endif

    // Asynchronous reset during iteration 4 discards the operation.
    launch(1'b0, 8'd9, 8'd9);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(res_valid), 32'h0);
    check("arst_product", 32'(res_product), 32'h0);
    check("arst_id", 32'(res_id), 32'h0);
    check("arst_ready", 32'({req1_ready, req0_ready}), 32'h0);
`ifdef BOOTH_MULT_SCHED_STATS_EN
    check("arst_ops", 32'(ops_done), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    single_op(1'b1, 8'd5, 8'd6, 16'h001E);

    // Fairness: both requesters held valid, results drained immediately.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req0_m = 8'd7;  req0_q = 8'hFD;
    req1_m = 8'hFA; req1_q = 8'd9;
    req0_valid = 1'b1; req1_valid = 1'b1;
    res_ready = 1'b1;
    #1;
    check("rr_first", 32'({req1_ready, req0_ready}), 32'h1);
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (!res_valid && t < 40) begin
        @(negedge clk);
        t++;
      end
      check("rr_id", 32'(res_id), 32'(k % 2));
      check("rr_product", 32'(res_product), (k % 2 == 1) ? 32'h0000FFCA : 32'h0000FFEB);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
